alu_issue: RTL and testbench

- Producer end of the ALU operation interface. Accepts a fetched RV32I instruction word plus register-file read data on a valid/ready handshake.
- Decodes the integer ALU subset into alu_control, operand1, operand2 and shamt, and presents them to the execute stage from a 2-entry skid buffer with a registered in_ready.
- Sits between register read and the combinational ALU. Flags unsupported encodings instead of dropping them.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_decode.sv | 78 +++++++
 rtl/alu_issue.sv | 91 +++++++++
 tb/tb_alu_issue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue slice: op codes, RV32I field
// constants and the decoded-operation record held in the skid buffer.
package alu_pkg;

    typedef enum logic [31:0] {
        ALU_ADD = 32'd0,
        ALU_SUB = 32'd1,
        ALU_AND = 32'd2,
        ALU_OR  = 32'd3,
        ALU_XOR = 32'd4
    } alu_control_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_control_t control;
        logic [31:0]  operand1;
        logic [31:0]  operand2;
        logic         illegal;
    } alu_op_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of the RV32I integer ALU subset into an alu_op_t.
// Unsupported encodings produce an ADD of zeros flagged as illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output alu_op_t     op_o
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  imm;
    alu_control_t ctrl;
    logic         legal;
    logic         use_imm;
    logic         unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm    = {{20{instr_i[31]}}, instr_i[31:20]};

    // rd and rs1 index fields are resolved upstream by the register read
    assign unused_fields = ^{instr_i[11:7], instr_i[19:15]};

    always_comb begin
        ctrl    = ALU_ADD;
        legal   = 1'b0;
        use_imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            ctrl  = ALU_ADD;
                            legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            ctrl  = ALU_SUB;
                            legal = 1'b1;
                        end
                    end
                    F3_XOR: begin ctrl = ALU_XOR; legal = (funct7 == F7_BASE); end
                    F3_OR:  begin ctrl = ALU_OR;  legal = (funct7 == F7_BASE); end
                    F3_AND: begin ctrl = ALU_AND; legal = (funct7 == F7_BASE); end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                legal   = 1'b1;
                case (funct3)
                    F3_ADD_SUB: ctrl = ALU_ADD;
                    F3_XOR:     ctrl = ALU_XOR;
                    F3_OR:      ctrl = ALU_OR;
                    F3_AND:     ctrl = ALU_AND;
                    default:    legal = 1'b0;
                endcase
            end
            default: ;
        endcase

        if (legal) begin
            op_o.control  = ctrl;
            op_o.operand1 = rs1_i;
            op_o.operand2 = use_imm ? imm : rs2_i;
            op_o.illegal  = 1'b0;
        end else begin
            op_o.control  = ALU_ADD;
            op_o.operand1 = '0;
            op_o.operand2 = '0;
            op_o.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decodes incoming ALU instructions and presents them to execute from a
// 2-entry skid buffer; in_ready is registered so upstream sees no comb path.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     alu_control,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      shamt,
    output logic            illegal
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    alu_op_t    dec_op;
    alu_op_t    mem_q [DEPTH];
    alu_op_t    head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q;
    logic       accept, issue;

    alu_decode u_dec (
        .instr_i (instr),
        .rs1_i   (rs1_data),
        .rs2_i   (rs2_data),
        .op_o    (dec_op)
    );

    assign accept = in_valid && in_ready_q;
    assign issue  = out_valid && out_ready;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            cnt_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) wr_ptr_d = ~wr_ptr_q;
            if (issue)  rd_ptr_d = ~rd_ptr_q;
            case ({accept, issue})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (accept && !flush) mem_q[wr_ptr_q] <= dec_op;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != FULL);
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign in_ready    = in_ready_q;
    assign out_valid   = (cnt_q != 2'd0);
    assign alu_control = head.control;
    assign operand1    = head.operand1;
    assign operand2    = head.operand2;
    assign shamt       = head.operand2[4:0];
    assign illegal     = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure ordering,
// illegal encodings, flush and asynchronous reset.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] instr, rs1_data, rs2_data, alu_control, operand1, operand2;
    logic [4:0]  shamt;
    int          checks = 0;
    int          errors = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_control(alu_control), .operand1(operand1),
        .operand2(operand2), .shamt(shamt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, OPC_OP_IMM};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_ctrl",      alu_control,    32'd0);
        check("rst_op1",       operand1,       32'd0);
        check("rst_op2",       operand2,       32'd0);
        check("rst_shamt",     32'(shamt),     32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);

        // Streaming with out_ready high: each op is accepted as the previous issues
        out_ready = 1'b1;
        drive(rtype(F7_BASE, F3_ADD_SUB), 32'd5, 32'd7);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_ctrl",  alu_control,    32'd0);
        check("add_op1",   operand1,       32'd5);
        check("add_op2",   operand2,       32'd7);
        check("add_shamt", 32'(shamt),     32'd7);
        check("add_ill",   32'(illegal),   32'd0);
        drive(rtype(F7_ALT, F3_ADD_SUB), 32'd9, 32'd3);
        tick();
        check("sub_ctrl",  alu_control,   32'd1);
        check("sub_op1",   operand1,      32'd9);
        check("sub_ready", 32'(in_ready), 32'd1);
        drive(itype(12'hFFF, F3_ADD_SUB), 32'd10, 32'd99);
        tick();
        check("addi_ctrl",  alu_control, 32'd0);
        check("addi_op1",   operand1,    32'd10);
        check("addi_op2",   operand2,    32'hFFFF_FFFF);
        check("addi_shamt", 32'(shamt),  32'd31);
        drive(itype(12'h7FF, F3_XOR), 32'd1, 32'd99);
        tick();
        check("xori_ctrl", alu_control, 32'd4);
        check("xori_op2",  operand2,    32'h0000_07FF);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: third op is held until a slot frees
        out_ready = 1'b0;
        drive(rtype(F7_BASE, F3_OR), 32'd1, 32'd2);
        tick();
        check("bp1_ready", 32'(in_ready), 32'd1);
        check("bp1_ctrl",  alu_control,   32'd3);
        drive(rtype(F7_BASE, F3_AND), 32'd3, 32'd4);
        tick();
        check("bp2_ready", 32'(in_ready), 32'd0);
        check("bp2_ctrl",  alu_control,   32'd3);
        drive(itype(12'h0F0, F3_AND), 32'hFF, 32'd0);
        tick();
        check("bp3_ready", 32'(in_ready), 32'd0);
        check("bp3_op1",   operand1,      32'd1);
        out_ready = 1'b1;
        tick();
        check("iss1_ready", 32'(in_ready), 32'd1);
        check("iss1_ctrl",  alu_control,   32'd2);
        check("iss1_op1",   operand1,      32'd3);
        tick();
        in_valid = 1'b0;
        check("iss2_ctrl", alu_control, 32'd2);
        check("iss2_op1",  operand1,    32'hFF);
        check("iss2_op2",  operand2,    32'h0F0);
        tick();
        check("iss3_valid", 32'(out_valid), 32'd0);

        // Illegal encodings: load opcode and OP with funct3=001
        out_ready = 1'b0;
        drive({12'h004, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'd5, 32'd6);
        tick();
        check("ld_valid", 32'(out_valid), 32'd1);
        check("ld_ill",   32'(illegal),   32'd1);
        check("ld_ctrl",  alu_control,    32'd0);
        check("ld_op1",   operand1,       32'd0);
        check("ld_op2",   operand2,       32'd0);
        out_ready = 1'b1;
        drive(rtype(F7_BASE, 3'b001), 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        check("sll_ill", 32'(illegal), 32'd1);
        check("sll_op1", operand1,     32'd0);
        tick();
        check("ill_drain", 32'(out_valid), 32'd0);

        // Flush with full buffer and with a simultaneous accept
        out_ready = 1'b0;
        drive(rtype(F7_BASE, F3_ADD_SUB), 32'd1, 32'd1);
        tick();
        drive(rtype(F7_ALT, F3_ADD_SUB), 32'd2, 32'd1);
        tick();
        check("fl_full", 32'(in_ready), 32'd0);
        drive(rtype(F7_BASE, F3_XOR), 32'd7, 32'd7);
        flush = 1'b1;
        tick();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready),  32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_acc_valid", 32'(out_valid), 32'd0);
        tick();
        check("fl_gone", 32'(out_valid), 32'd0);
        drive(rtype(F7_BASE, F3_OR), 32'd6, 32'd5);
        tick();
        check("post_fl_ctrl", alu_control, 32'd3);
        check("post_fl_op1",  operand1,    32'd6);

        // Asynchronous reset between clock edges
        drive(rtype(F7_BASE, F3_AND), 32'd8, 32'd9);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready),  32'd1);
        check("arst_ctrl",  alu_control,    32'd0);
        check("arst_op1",   operand1,       32'd0);
        check("arst_op2",   operand2,       32'd0);
        check("arst_ill",   32'(illegal),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
